fifo_axis_level: RTL
====================

Name: fifo_axis_level

Overview:
- Parametrised AXI-Stream-style synchronous FIFO. Successor to the fixed-behaviour FIFO.
- Adds a power-of-two depth with extra-bit pointers, so full and empty are exact.
- Adds a first-word-fall-through output register, a fill-level output, registered almost-full/almost-empty flags and a synchronous flush.
- Sits between streaming producers and consumers in the datapath, single clock domain.

Parameters:
- p_width, 8, data word width in bits.
- p_depth, 32, RAM depth in words; power of two, >= 4.
- p_afull_thresh, 28, o_almost_full asserts when level >= this; range 1..p_depth+1.
- p_aempty_thresh, 2, o_almost_empty asserts when level <= this; range 0..p_depth.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous clear of all contents; pointers, level and flags return to reset values.
- i_data_in  in  p_width  input data.
- i_valid_in  in  1  input valid.
- o_ready_in  out  1  input ready.
- o_data_out  out  p_width  output data (registered).
- o_valid_out  out  1  output valid (registered).
- i_ready_out  in  1  downstream ready.
- o_level  out  $clog2(p_depth+2)  words held (RAM + output register), 0..p_depth+1.
- o_almost_full  out  1  registered threshold flag.
- o_almost_empty  out  1  registered threshold flag.

Behaviour:
- Reset (i_reset=1) has priority over i_flush; i_flush has priority over traffic. Under either:
  - wr_ptr = 0, rd_ptr = 0.
  - o_valid_out = 0, o_data_out = 0, o_level = 0.
  - o_almost_full = 0, o_almost_empty = 1.
  - o_ready_in = 1 from the first cycle after reset/flush.
  - Inputs are ignored during the reset/flush cycle.
- Pointers: $clog2(p_depth)+1 bits.
  - ram_empty = (wr_ptr == rd_ptr).
  - ram_full = MSBs differ and lower bits equal.
  - Wrap-around is natural binary overflow.
- o_ready_in = !ram_full. It is combinational from registered pointers only; there is no combinational path from any input.
- Write: when i_valid_in && o_ready_in, mem[wr_ptr low bits] <= i_data_in and wr_ptr increments.
- Prefetch: when !ram_empty && (!o_valid_out || i_ready_out):
  - o_data_out <= mem[rd_ptr low bits] (synchronous read).
  - rd_ptr increments.
  - o_valid_out <= 1.
- Output drop: when o_valid_out && i_ready_out && ram_empty, o_valid_out <= 0.
- Prefetch uses pointer state before the edge. A word written at edge k is not bypassed; o_valid_out rises after edge k+1 when the FIFO was empty (latency 2 edges from the accepting edge to valid).
- AXI rule: while o_valid_out && !i_ready_out, o_data_out and o_valid_out hold stable.
- Throughput: one word per cycle sustained in both directions when neither side stalls.
- Level:
  - +1 on input handshake only.
  - -1 on output handshake (o_valid_out && i_ready_out) only.
  - Unchanged when both or neither occur.
  - Total capacity is p_depth+1 words.
- Flags are computed from the next-state level, so they are valid in the same cycle as o_level:
  - o_almost_full = (level_next >= p_afull_thresh).
  - o_almost_empty = (level_next <= p_aempty_thresh).
- Simultaneous write with RAM full: impossible by construction, because o_ready_in = 0.
- Read with empty FIFO: no effect.
- Order is preserved across pointer wrap.

Decomposition:
- Shared package fifo_axis_pkg holds:
  - Function f_level_width(depth) returning $clog2(depth+2).
  - Function f_is_pow2(depth), used in an elaboration-time check that fails on a non-power-of-two p_depth or out-of-range thresholds.
- Sub-module: reuse the team's binary_counter (p_up_count=1, p_init_value=0, p_width=$clog2(p_depth)+1) twice, for wr_ptr and rd_ptr.
  - Drive i_sclr from i_flush.
  - Drive i_ce from the write and prefetch enables respectively.

Test Plan:
All scenarios use p_width=8, p_depth=8, p_afull_thresh=6, p_aempty_thresh=1.
1. Reset, then a single write of 0xA5 accepted at edge k -> o_valid_out=1 and o_data_out=0xA5 after edge k+1; o_level=1; o_almost_empty=1.
2. i_ready_out=0, stream 0x00..0x0A -> exactly 9 words accepted (0x00..0x08); o_ready_in=0 after the 9th; o_level=9; o_almost_full rises when o_level reaches 6; o_data_out held at 0x00 throughout.
3. From the full state, drain with i_ready_out toggled 1,0,1,0 -> outputs 0x00..0x08 in order; o_data_out stable on stall cycles; o_valid_out falls after the handshake of 0x08; o_level=0.
4. Continuous valid and ready, 50 words 0x00..0x31 -> all received in order; both pointers wrap at least 3 times; o_level constant after fill; one word per cycle.
5. i_flush while o_level=5 and i_valid_in=1 -> next cycle o_valid_out=0, o_level=0, o_almost_empty=1, o_ready_in=1; a following write of 0x3C emerges as the next output with no stale data.
6. i_reset asserted mid-burst with simultaneous input and output handshakes -> all outputs at reset values next cycle; post-reset traffic 0x11, 0x22 delivered in order.

Source files
------------

// File: rtl/fifo_axis_pkg.sv
// Shared definitions for the AXI-Stream level FIFO.
//   f_level_width : width of the fill-level output for a given RAM depth
//                   (level spans 0..depth+1 because of the output register).
//   f_is_pow2     : true when depth is a non-zero power of two.
package fifo_axis_pkg;

  function automatic int f_level_width(input int depth);
    return $clog2(depth + 2);
  endfunction

  function automatic bit f_is_pow2(input int depth);
    return (depth > 0) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_axis_level_if.sv
// Streaming handshake bundle for fifo_axis_level.
//   i_data_in / i_valid_in / o_ready_in    : producer -> FIFO
//   o_data_out / o_valid_out / i_ready_out : FIFO -> consumer
// slave  : the FIFO's view.
// master : the surrounding datapath's view.
interface fifo_axis_level_if #(
  parameter int p_width = 8
);
  logic [p_width-1:0] i_data_in;
  logic               i_valid_in;
  logic               o_ready_in;
  logic [p_width-1:0] o_data_out;
  logic               o_valid_out;
  logic               i_ready_out;

  modport slave (
    input  i_data_in, i_valid_in, i_ready_out,
    output o_ready_in, o_data_out, o_valid_out
  );

  modport master (
    output i_data_in, i_valid_in, i_ready_out,
    input  o_ready_in, o_data_out, o_valid_out
  );
endinterface

// File: rtl/binary_counter.sv
// Free-running binary counter with synchronous reset, synchronous clear and
// count enable.
//   i_clk    : clock, rising edge
//   i_reset  : synchronous active-high reset to p_init_value
//   i_sclr   : synchronous clear to p_init_value (below reset in priority)
//   i_ce     : count enable
//   o_count  : current count; wraps by natural binary overflow
module binary_counter #(
  parameter int          p_width      = 8,
  parameter bit          p_up_count   = 1'b1,
  parameter int unsigned p_init_value = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_sclr,
  input  logic               i_ce,
  output logic [p_width-1:0] o_count
);

  localparam logic [p_width-1:0] lp_init = p_width'(p_init_value);

  logic [p_width-1:0] count_q;
  logic [p_width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_sclr) begin
      count_d = lp_init;
    end else if (i_ce) begin
      if (p_up_count) count_d = count_q + p_width'(1);
      else            count_d = count_q - p_width'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) count_q <= lp_init;
    else         count_q <= count_d;
  end

  assign o_count = count_q;

endmodule

// File: rtl/fifo_axis_level.sv
// Synchronous AXI-Stream FIFO with first-word-fall-through output register,
// fill level and registered almost-full / almost-empty flags.
//   i_clk, i_reset  : clock; synchronous active-high reset
//   i_flush         : synchronous clear of all contents (below reset)
//   bus             : stream handshake (fifo_axis_level_if.slave)
//   o_level         : words held in RAM plus output register, 0..p_depth+1
//   o_almost_full   : level >= p_afull_thresh
//   o_almost_empty  : level <= p_aempty_thresh
module fifo_axis_level
  import fifo_axis_pkg::*;
#(
  parameter int p_width         = 8,
  parameter int p_depth         = 32,
  parameter int p_afull_thresh  = 28,
  parameter int p_aempty_thresh = 2,
  localparam int lp_lw          = f_level_width(p_depth)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  fifo_axis_level_if.slave     bus,
  output logic [lp_lw-1:0]     o_level,
  output logic                 o_almost_full,
  output logic                 o_almost_empty
);

  localparam int lp_aw = $clog2(p_depth);
  localparam int lp_pw = lp_aw + 1;
  localparam logic [lp_lw-1:0] lp_afull  = lp_lw'(p_afull_thresh);
  localparam logic [lp_lw-1:0] lp_aempty = lp_lw'(p_aempty_thresh);

  if (!f_is_pow2(p_depth) || (p_depth < 4) ||
      (p_afull_thresh < 1) || (p_afull_thresh > p_depth + 1) ||
      (p_aempty_thresh < 0) || (p_aempty_thresh > p_depth)) begin : g_bad_params
    $error("fifo_axis_level: illegal depth or threshold parameters");
  end

  logic [p_width-1:0] mem_q [p_depth];

  logic [lp_pw-1:0] wr_ptr;
  logic [lp_pw-1:0] rd_ptr;
  logic             ram_empty;
  logic             ram_full;
  logic             wr_en;
  logic             pf_en;
  logic             out_hs;

  logic [p_width-1:0] data_q,   data_d;
  logic               valid_q,  valid_d;
  logic [lp_lw-1:0]   level_q,  level_d;
  logic               afull_q,  afull_d;
  logic               aempty_q, aempty_d;

  assign ram_empty = (wr_ptr == rd_ptr);
  assign ram_full  = (wr_ptr[lp_pw-1] != rd_ptr[lp_pw-1]) &&
                     (wr_ptr[lp_aw-1:0] == rd_ptr[lp_aw-1:0]);

  // Enables use only registered state plus inputs; ready itself depends on
  // pointers alone, so there is no input-to-ready path.
  assign wr_en  = bus.i_valid_in && !ram_full;
  assign pf_en  = !ram_empty && (!valid_q || bus.i_ready_out);
  assign out_hs = valid_q && bus.i_ready_out;

  binary_counter #(
    .p_width      (lp_pw),
    .p_up_count   (1'b1),
    .p_init_value (0)
  ) u_wr_ptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sclr  (i_flush),
    .i_ce    (wr_en),
    .o_count (wr_ptr)
  );

  binary_counter #(
    .p_width      (lp_pw),
    .p_up_count   (1'b1),
    .p_init_value (0)
  ) u_rd_ptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sclr  (i_flush),
    .i_ce    (pf_en),
    .o_count (rd_ptr)
  );

  always_ff @(posedge i_clk) begin
    if (wr_en && !i_reset && !i_flush) begin
      mem_q[wr_ptr[lp_aw-1:0]] <= bus.i_data_in;
    end
  end

  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    level_d  = level_q;
    afull_d  = afull_q;
    aempty_d = aempty_q;

    if (i_flush) begin
      data_d   = '0;
      valid_d  = 1'b0;
      level_d  = '0;
      afull_d  = 1'b0;
      aempty_d = 1'b1;
    end else begin
      // Refill takes precedence; otherwise a consumed word with nothing
      // behind it in RAM empties the output register.
      if (pf_en) begin
        data_d  = mem_q[rd_ptr[lp_aw-1:0]];
        valid_d = 1'b1;
      end else if (out_hs) begin
        valid_d = 1'b0;
      end

      case ({wr_en, out_hs})
        2'b10:   level_d = level_q + lp_lw'(1);
        2'b01:   level_d = level_q - lp_lw'(1);
        default: level_d = level_q;
      endcase

      afull_d  = (level_d >= lp_afull);
      aempty_d = (level_d <= lp_aempty);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      level_q  <= '0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      level_q  <= level_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign bus.o_ready_in  = !ram_full;
  assign bus.o_data_out  = data_q;
  assign bus.o_valid_out = valid_q;
  assign o_level         = level_q;
  assign o_almost_full   = afull_q;
  assign o_almost_empty  = aempty_q;

endmodule
